// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage view of the hazard controller: instruction fields in, stall/refresh out.
// Signals: id_* (ID instruction), exc_oc, stall/refresh per boundary, flush_busy.
interface pipe_hazard_ctrl_if #(
   parameter int NSTAGE = 5,
   parameter int RW     = 5,
   parameter int LATW   = 2
);
   logic              id_valid;
   logic              id_branch;
   logic              id_rs_ren;
   logic [RW-1:0]     id_rs;
   logic              id_rt_ren;
   logic [RW-1:0]     id_rt;
   logic              id_wen;
   logic [RW-1:0]     id_wreg;
   logic [LATW-1:0]   id_wlat;
   logic              exc_oc;
   logic [NSTAGE-2:0] stall;
   logic [NSTAGE-2:0] refresh;
   logic              flush_busy;

   modport master (
      output id_valid, id_branch, id_rs_ren, id_rs,
      output id_rt_ren, id_rt, id_wen, id_wreg, id_wlat,
      output exc_oc,
      input  stall, refresh, flush_busy
   );

   modport slave (
      input  id_valid, id_branch, id_rs_ren, id_rs,
      input  id_rt_ren, id_rt, id_wen, id_wreg, id_wlat,
      input  exc_oc,
      output stall, refresh, flush_busy
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: per-register latency scoreboard + exception flush sequencer.
// Ports: clk, resetn (async low), hz (slave: id_*, exc_oc -> stall, refresh, flush_busy);
// HAZ_PERF_EN adds stall_cycles (saturating count of cycles with stall[0]=1).
module pipe_hazard_ctrl #(
   parameter int NSTAGE    = 5,
   parameter int RW        = 5,
   parameter int LATW      = 2,
   parameter int FLUSH_CYC = 1
) (
   input  logic clk,
   input  logic resetn,
   pipe_hazard_ctrl_if.slave hz
`ifdef HAZ_PERF_EN
   ,
   output logic [31:0] stall_cycles
`endif
);
   localparam int NREG = 2 ** RW;
   localparam int NB   = NSTAGE - 1;
   localparam int FW   = (FLUSH_CYC > 0) ? $clog2(FLUSH_CYC + 1) : 1;

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nx;
   logic [FW-1:0]   r_fcnt;
   logic [FW-1:0]   w_fcnt_nx;
   logic [LATW-1:0] r_cnt [NREG];

   logic [LATW-1:0] w_thr;
   logic [LATW-1:0] w_rs_cnt;
   logic [LATW-1:0] w_rt_cnt;
   logic            w_haz;
   logic            w_issue;
   logic [NB-1:0]   w_stall;
   logic [NB-1:0]   w_refresh;

   // r0 is hardwired zero, never a pending producer
   assign w_rs_cnt = (hz.id_rs == '0) ? '0 : r_cnt[hz.id_rs];
   assign w_rt_cnt = (hz.id_rt == '0) ? '0 : r_cnt[hz.id_rt];

   // branches consume in ID, one stage earlier than EX consumers
   assign w_thr = hz.id_branch ? LATW'(0) : LATW'(1);

   assign w_haz = hz.id_valid &
                  ((hz.id_rs_ren & (w_rs_cnt > w_thr)) |
                   (hz.id_rt_ren & (w_rt_cnt > w_thr)));

   assign w_issue = hz.id_valid & hz.id_wen & (hz.id_wreg != '0) &
                    ~w_stall[0] & ~hz.exc_oc & (r_state == IDLE);

   always_comb begin
      w_stall   = '0;
      w_refresh = '0;
      if (!resetn) begin
         w_refresh = '1;
      end else if (hz.exc_oc) begin
         // WB instruction is older than the exception and still retires
         w_refresh = {1'b0, {(NB-1){1'b1}}};
      end else if (r_state == FLUSH) begin
         w_refresh[0] = 1'b1;
         w_refresh[1] = ~hz.id_valid;
      end else if (w_haz) begin
         w_stall[0]   = 1'b1;
         w_refresh[1] = 1'b1;
      end else begin
         w_refresh[1] = ~hz.id_valid;
      end
   end

   assign hz.stall      = w_stall;
   assign hz.refresh    = w_refresh;
   assign hz.flush_busy = (r_state == FLUSH);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
      end else begin
         for (int r = 0; r < NREG; r++) begin
            if (hz.exc_oc)
               r_cnt[r] <= '0;
            else if (w_issue && hz.id_wreg == RW'(r))
               r_cnt[r] <= hz.id_wlat;
            else if (r_cnt[r] != '0)
               r_cnt[r] <= r_cnt[r] - LATW'(1);
         end
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_fcnt_nx  = r_fcnt;
      unique case (r_state)
         IDLE: begin
            if (hz.exc_oc && FLUSH_CYC > 0) begin
               w_state_nx = FLUSH;
               w_fcnt_nx  = FW'(FLUSH_CYC);
            end
         end
         FLUSH: begin
            if (hz.exc_oc) begin
               w_fcnt_nx = FW'(FLUSH_CYC);
            end else if (r_fcnt == FW'(1)) begin
               w_state_nx = IDLE;
               w_fcnt_nx  = '0;
            end else begin
               w_fcnt_nx = r_fcnt - FW'(1);
            end
         end
         default: begin
            w_state_nx = IDLE;
            w_fcnt_nx  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
         r_fcnt  <= '0;
      end else begin
         r_state <= w_state_nx;
         r_fcnt  <= w_fcnt_nx;
      end
   end

`ifdef HAZ_PERF_EN
   logic [31:0] r_stall_cycles;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         r_stall_cycles <= '0;
      else if (w_stall[0] && r_stall_cycles != 32'hFFFF_FFFF)
         r_stall_cycles <= r_stall_cycles + 32'd1;
   end

   assign stall_cycles = r_stall_cycles;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (FLUSH_CYC=2).
// Covers reset, scoreboard bubbles, WAW/r0, exception flush, async reset.
module tb_pipe_hazard_ctrl;
   localparam int NSTAGE = 5;
   localparam int RW     = 5;
   localparam int LATW   = 2;

   logic clk;
   logic resetn;
`ifdef HAZ_PERF_EN
   logic [31:0] stall_cycles;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   pipe_hazard_ctrl_if #(.NSTAGE(NSTAGE), .RW(RW), .LATW(LATW)) hz_if ();

   pipe_hazard_ctrl #(
      .NSTAGE(NSTAGE), .RW(RW), .LATW(LATW), .FLUSH_CYC(2)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .hz(hz_if.slave)
`ifdef HAZ_PERF_EN
      ,
      .stall_cycles(stall_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // valid, branch, rs_ren, rs, rt_ren, rt, wen, wreg, wlat
   task automatic set_id(input logic v, input logic br,
                         input logic rse, input logic [4:0] rs,
                         input logic rte, input logic [4:0] rt,
                         input logic we, input logic [4:0] wr,
                         input logic [1:0] wl);
      hz_if.id_valid  = v;
      hz_if.id_branch = br;
      hz_if.id_rs_ren = rse;
      hz_if.id_rs     = rs;
      hz_if.id_rt_ren = rte;
      hz_if.id_rt     = rt;
      hz_if.id_wen    = we;
      hz_if.id_wreg   = wr;
      hz_if.id_wlat   = wl;
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [3:0] st,
                          input logic [3:0] rf, input logic fb);
      check({tag, ".stall"}, 32'(hz_if.stall), 32'(st));
      check({tag, ".refresh"}, 32'(hz_if.refresh), 32'(rf));
      check({tag, ".busy"}, 32'(hz_if.flush_busy), 32'(fb));
   endtask

   initial begin
      resetn       = 1'b0;
      hz_if.exc_oc = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk_out("reset", 4'b0000, 4'b1111, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #3 resetn = 1'b1;
      tick();

      // ALU producer: no bubble
      set_id(1, 0, 0, 0, 0, 0, 1, 5'd3, 2'd0);
      chk_out("alu_prod", 4'b0000, 4'b0000, 1'b0);
      tick();
      set_id(1, 0, 1, 5'd3, 0, 0, 0, 0, 0);
      chk_out("alu_use", 4'b0000, 4'b0000, 1'b0);
      tick();

      // load -> ALU: one bubble
      set_id(1, 0, 0, 0, 0, 0, 1, 5'd5, 2'd2);
      tick();
      set_id(1, 0, 1, 5'd5, 0, 0, 1, 5'd6, 2'd0);
      chk_out("ld_use1", 4'b0001, 4'b0010, 1'b0);
      tick();
      chk_out("ld_use2", 4'b0000, 4'b0000, 1'b0);
      tick();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk_out("bubble", 4'b0000, 4'b0010, 1'b0);
      tick();

      // load -> branch on rt: two bubbles
      set_id(1, 0, 0, 0, 0, 0, 1, 5'd5, 2'd2);
      tick();
      set_id(1, 1, 0, 0, 1, 5'd5, 0, 0, 0);
      chk_out("ld_br1", 4'b0001, 4'b0010, 1'b0);
      tick();
      chk_out("ld_br2", 4'b0001, 4'b0010, 1'b0);
      tick();
      chk_out("ld_br3", 4'b0000, 4'b0000, 1'b0);
      tick();

      // WAW: newest (ALU) latency wins
      set_id(1, 0, 0, 0, 0, 0, 1, 5'd7, 2'd2);
      tick();
      set_id(1, 0, 0, 0, 0, 0, 1, 5'd7, 2'd0);
      check("waw_issue.stall", 32'(hz_if.stall), 32'h0);
      tick();
      set_id(1, 1, 1, 5'd7, 0, 0, 0, 0, 0);
      check("waw_use.stall", 32'(hz_if.stall), 32'h0);
      tick();

      // r0 never tracked
      set_id(1, 0, 0, 0, 0, 0, 1, 5'd0, 2'd3);
      tick();
      set_id(1, 1, 1, 5'd0, 1, 5'd0, 0, 0, 0);
      check("r0_use.stall", 32'(hz_if.stall), 32'h0);
      tick();

      // exception during load-use stall; excepting cycle's write is dropped
      set_id(1, 0, 0, 0, 0, 0, 1, 5'd5, 2'd2);
      tick();
      set_id(1, 0, 1, 5'd5, 0, 0, 1, 5'd8, 2'd3);
      check("exc_pre.stall", 32'(hz_if.stall), 32'h1);
      hz_if.exc_oc = 1'b1;
      #1;
      chk_out("exc_cyc", 4'b0000, 4'b0111, 1'b0);
      tick();
      hz_if.exc_oc = 1'b0;
      #1;
      chk_out("flush1", 4'b0000, 4'b0001, 1'b1);
      tick();
      chk_out("flush2", 4'b0000, 4'b0001, 1'b1);
      tick();
      set_id(1, 1, 1, 5'd8, 1, 5'd5, 0, 0, 0);
      chk_out("post_flush", 4'b0000, 4'b0000, 1'b0);
      tick();

      // exc_oc while flushing reloads the counter
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      hz_if.exc_oc = 1'b1;
      tick();
      hz_if.exc_oc = 1'b0;
      #1;
      chk_out("rl_a", 4'b0000, 4'b0011, 1'b1);
      tick();
      hz_if.exc_oc = 1'b1;
      #1;
      chk_out("rl_exc", 4'b0000, 4'b0111, 1'b1);
      tick();
      hz_if.exc_oc = 1'b0;
      #1;
      check("rl_b.busy", 32'(hz_if.flush_busy), 32'h1);
      tick();
      check("rl_c.busy", 32'(hz_if.flush_busy), 32'h1);
      tick();
      check("rl_d.busy", 32'(hz_if.flush_busy), 32'h0);
      tick();

      // async reset in the middle of a load-use stall
      set_id(1, 0, 0, 0, 0, 0, 1, 5'd5, 2'd2);
      tick();
      set_id(1, 0, 1, 5'd5, 0, 0, 0, 0, 0);
      check("rst_pre.stall", 32'(hz_if.stall), 32'h1);
      #1 resetn = 1'b0;
      #1;
      chk_out("rst_mid", 4'b0000, 4'b1111, 1'b0);
`ifdef HAZ_PERF_EN
      check("rst_mid.perf", stall_cycles, 32'h0);
`endif
      @(posedge clk);
      #2 resetn = 1'b1;
      #1;
      chk_out("rst_rel", 4'b0000, 4'b0000, 1'b0);
      tick();
      check("rst_after.stall", 32'(hz_if.stall), 32'h0);
`ifdef HAZ_PERF_EN
      check("rst_after.perf", stall_cycles, 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
